// File: rtl/cpu_sequencer.sv
// Control-state sequencer for the 16-bit CPU: one-hot phase strobes, instruction
// register, ALU flag register, JCX condition evaluation and retired-instruction counter.
module cpu_sequencer (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ena,
   input  logic [15:0] instr_in,
   input  logic        E2,
   input  logic [3:0]  flags_in,
   input  logic        flags_we,
   output logic        FETCH,
   output logic        EXEC1,
   output logic        EXEC2,
   output logic        HALT,
   output logic [15:0] instr,
   output logic [3:0]  flags,
   output logic        COND_result,
   output logic [15:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH = 4'b0001,
      S_EXEC1 = 4'b0010,
      S_EXEC2 = 4'b0100,
      S_HALT  = 4'b1000
   } state_t;

   localparam logic [15:0] NOP_INSTR = 16'h7C00;

   state_t      state;
   logic [15:0] instr_q;
   logic [3:0]  flags_q;
   logic [15:0] retired_q;

   logic [5:0]  op;
   logic        is_stp;
   logic        is_jcx;
   logic [2:0]  cc;

   assign op     = instr_q[14:9];
   assign is_stp = !instr_q[15] && (op == 6'b111111);
   assign is_jcx = !instr_q[15] && (op >= 6'd4) && (op <= 6'd11);
   assign cc     = {op[3], op[1:0]};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_FETCH;
         instr_q   <= NOP_INSTR;
         flags_q   <= '0;
         retired_q <= '0;
      end else if (ena) begin
         case (state)
            S_FETCH: begin
               state   <= S_EXEC1;
               instr_q <= instr_in;
            end
            S_EXEC1: begin
               // STP wins over a pending E2 request; both STP and single-cycle ops retire here
               if (is_stp) begin
                  state     <= S_HALT;
                  retired_q <= retired_q + 16'd1;
               end else if (E2) begin
                  state <= S_EXEC2;
               end else begin
                  state     <= S_FETCH;
                  retired_q <= retired_q + 16'd1;
               end
               if (flags_we) flags_q <= flags_in;
            end
            S_EXEC2: begin
               state     <= S_FETCH;
               retired_q <= retired_q + 16'd1;
               if (flags_we) flags_q <= flags_in;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      COND_result = 1'b0;
      if (is_jcx) begin
         case (cc)
            3'd0: COND_result =  flags_q[2];
            3'd1: COND_result = ~flags_q[2];
            3'd2: COND_result =  flags_q[1];
            3'd3: COND_result = ~flags_q[1];
            3'd4: COND_result =  flags_q[3];
            3'd5: COND_result = ~flags_q[3];
            3'd6: COND_result =  flags_q[0];
            default: COND_result = ~flags_q[0];
         endcase
      end
   end

   assign {HALT, EXEC2, EXEC1, FETCH} = state;
   assign instr   = instr_q;
   assign flags   = flags_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed, table-driven bench for cpu_sequencer: one row per clock edge, plus a
// hand-written counter wrap sequence.
module tb_cpu_sequencer;

   logic        CLK = 1'b0;
   logic        RESET, ena, E2, flags_we;
   logic [15:0] instr_in;
   logic [3:0]  flags_in;
   logic        FETCH, EXEC1, EXEC2, HALT, COND_result;
   logic [15:0] instr, retired;
   logic [3:0]  flags;

   int unsigned checks = 0;
   int unsigned errors = 0;

   localparam logic [3:0] ST_F = 4'b1000, ST_E1 = 4'b0100, ST_E2 = 4'b0010, ST_H = 4'b0001;

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] din;
      logic        e2;
      logic [3:0]  fin;
      logic        fwe;
      logic [3:0]  st;    // {FETCH,EXEC1,EXEC2,HALT}
      logic [15:0] ir;
      logic [3:0]  fl;
      logic        cond;
      logic [15:0] ret;
   } vec_t;

   vec_t vq[$];

   cpu_sequencer dut (
      .CLK(CLK), .RESET(RESET), .ena(ena), .instr_in(instr_in), .E2(E2),
      .flags_in(flags_in), .flags_we(flags_we), .FETCH(FETCH), .EXEC1(EXEC1),
      .EXEC2(EXEC2), .HALT(HALT), .instr(instr), .flags(flags),
      .COND_result(COND_result), .retired(retired)
   );

   always #5 CLK = ~CLK;

   function automatic void add(input logic rst, input logic en, input logic [15:0] din,
                               input logic e2, input logic [3:0] fin, input logic fwe,
                               input logic [3:0] st, input logic [15:0] ir,
                               input logic [3:0] fl, input logic cond, input logic [15:0] ret);
      vec_t v;
      v.rst = rst; v.en = en; v.din = din; v.e2 = e2; v.fin = fin; v.fwe = fwe;
      v.st = st; v.ir = ir; v.fl = fl; v.cond = cond; v.ret = ret;
      vq.push_back(v);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] st, input logic [15:0] ir,
                            input logic [3:0] fl, input logic cond, input logic [15:0] ret);
      check({tag, " strobes"}, {12'd0, FETCH, EXEC1, EXEC2, HALT}, {12'd0, st});
      check({tag, " instr"},   instr, ir);
      check({tag, " flags"},   {12'd0, flags}, {12'd0, fl});
      check({tag, " cond"},    {15'd0, COND_result}, {15'd0, cond});
      check({tag, " retired"}, retired, ret);
   endtask

   initial begin
      RESET = 1'b1; ena = 1'b0; E2 = 1'b0; flags_we = 1'b0;
      instr_in = 16'h0000; flags_in = 4'h0;

      //  rst en  din       e2  fin    fwe  st     ir        fl     cond ret
      add(1, 1, 16'h7C00, 0, 4'h0, 0, ST_F,  16'h7C00, 4'h0, 0, 16'd0);   // 0 reset
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_E1, 16'h7C00, 4'h0, 0, 16'd0);   // 1 NOP stream
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_F,  16'h7C00, 4'h0, 0, 16'd1);
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_E1, 16'h7C00, 4'h0, 0, 16'd1);
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_F,  16'h7C00, 4'h0, 0, 16'd2);
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_E1, 16'h7C00, 4'h0, 0, 16'd2);
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_F,  16'h7C00, 4'h0, 0, 16'd3);   // 6
      add(0, 1, 16'h8123, 1, 4'h0, 0, ST_E1, 16'h8123, 4'h0, 0, 16'd3);   // 7 E2 in FETCH ignored
      add(0, 1, 16'h7C00, 1, 4'h0, 0, ST_E2, 16'h8123, 4'h0, 0, 16'd3);   // 8 E2 taken
      add(0, 1, 16'h7C00, 1, 4'h0, 0, ST_F,  16'h8123, 4'h0, 0, 16'd4);   // 9
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_E1, 16'h7C00, 4'h0, 0, 16'd4);   // 10
      for (int i = 0; i < 3; i++)                                          // 11-13 stall
         add(0, 0, 16'h1234, 1, 4'hF, 1, ST_E1, 16'h7C00, 4'h0, 0, 16'd4);
      add(0, 1, 16'h7C00, 0, 4'h4, 1, ST_F,  16'h7C00, 4'h4, 0, 16'd5);   // 14 Z=1 written
      add(0, 1, 16'h0800, 0, 4'h0, 1, ST_E1, 16'h0800, 4'h4, 1, 16'd5);   // 15 op4 Z; fwe in FETCH ignored
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_F,  16'h0800, 4'h4, 1, 16'd6);
      add(0, 1, 16'h0A00, 0, 4'h0, 0, ST_E1, 16'h0A00, 4'h4, 0, 16'd6);   // 17 op5 ~Z
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_F,  16'h0A00, 4'h4, 0, 16'd7);
      add(0, 1, 16'h1600, 0, 4'h0, 0, ST_E1, 16'h1600, 4'h4, 1, 16'd7);   // 19 op11 ~V
      add(0, 1, 16'h7C00, 0, 4'h1, 1, ST_F,  16'h1600, 4'h1, 0, 16'd8);   // 20 V=1 next cycle
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_E1, 16'h7C00, 4'h1, 0, 16'd8);
      add(0, 1, 16'h7C00, 0, 4'h4, 1, ST_F,  16'h7C00, 4'h4, 0, 16'd9);   // 22 NOP with Z=1
      add(0, 1, 16'h0600, 0, 4'h0, 0, ST_E1, 16'h0600, 4'h4, 0, 16'd9);   // 23 op3 not JCX
      add(0, 1, 16'h7C00, 0, 4'h0, 0, ST_F,  16'h0600, 4'h4, 0, 16'd10);
      add(0, 1, 16'h8000, 0, 4'h0, 0, ST_E1, 16'h8000, 4'h4, 0, 16'd10);  // 25
      add(0, 1, 16'h7C00, 1, 4'h0, 0, ST_E2, 16'h8000, 4'h4, 0, 16'd10);
      add(1, 1, 16'h7C00, 0, 4'h0, 0, ST_F,  16'h7C00, 4'h0, 0, 16'd0);   // 27 abort in EXEC2
      add(0, 1, 16'h7E00, 1, 4'h0, 0, ST_E1, 16'h7E00, 4'h0, 0, 16'd0);   // 28 STP
      add(0, 1, 16'h7C00, 1, 4'h0, 0, ST_H,  16'h7E00, 4'h0, 0, 16'd1);   // 29 STP beats E2
      for (int i = 0; i < 11; i++)
         add(0, 1, 16'h7C00, i[0], 4'hF, 1, ST_H, 16'h7E00, 4'h0, 0, 16'd1);
      add(1, 1, 16'h7C00, 0, 4'h0, 0, ST_F,  16'h7C00, 4'h0, 0, 16'd0);   // leave HALT

      @(negedge CLK);
      for (int i = 0; i < vq.size(); i++) begin
         RESET = vq[i].rst; ena = vq[i].en; instr_in = vq[i].din; E2 = vq[i].e2;
         flags_in = vq[i].fin; flags_we = vq[i].fwe;
         @(posedge CLK); #1;
         check_all($sformatf("row%0d", i), vq[i].st, vq[i].ir, vq[i].fl, vq[i].cond, vq[i].ret);
      end

      // Counter wrap: preload the counter near its limit, then retire two NOPs.
      RESET = 1'b0; ena = 1'b1; E2 = 1'b0; flags_we = 1'b0; instr_in = 16'h7C00;
      force dut.retired_q = 16'hFFFE;
      #1 release dut.retired_q;
      check("wrap preload", retired, 16'hFFFE);
      @(posedge CLK); #1;
      check_all("wrap a1", ST_E1, 16'h7C00, 4'h0, 1'b0, 16'hFFFE);
      @(posedge CLK); #1;
      check_all("wrap a2", ST_F, 16'h7C00, 4'h0, 1'b0, 16'hFFFF);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      check_all("wrap b2", ST_F, 16'h7C00, 4'h0, 1'b0, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
